fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 54 +++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, the fetch buffer entry type and the pre-decode helper.
package cpu_pkg;
    localparam int ADDR_W = 15;
    localparam int INST_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // A-instructions carry a 0 in the top bit.
    function automatic logic is_a_inst(input logic [INST_W-1:0] inst);
        return ~inst[INST_W-1];
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction stream from fetch to decode: valid/ready handshake plus payload.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_is_a;

    modport master (output out_valid, out_inst, out_pc, out_is_a, input out_ready);
    modport slave  (input out_valid, out_inst, out_pc, out_is_a, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries with flush and occupancy count.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Guard locally so a misbehaving caller can never over/underflow.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks fetch_pc over a combinational ROM and buffers words for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master      fo
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  cnt;
    logic              push, pop;
    fetch_entry_t      head, wentry;

    assign rom_addr     = fetch_pc;
    assign fo.out_valid = (cnt != '0);
    assign pop          = fo.out_valid && fo.out_ready;
    // A pop frees a slot in the same cycle, so a full buffer still streams.
    assign push         = run && !redirect_valid && ((cnt < CNT_W'(DEPTH)) || pop);
    assign wentry       = '{inst: rom_data, pc: fetch_pc};

    assign fo.out_inst  = head.inst;
    assign fo.out_pc    = head.pc;
    assign fo.out_is_a  = is_a_inst(head.inst);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .count (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= redirect_pc;
        else if (push)
            fetch_pc <= fetch_pc + 1'b1;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table plus randomized run against a queue-based fetch model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [14:0] redirect_pc = '0;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] mem [32768];

    fetch_unit_if fo_if ();

    assign rom_data = mem[rom_addr];

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(15'd0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fo             (fo_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of fetched words and a next-address counter.
    typedef struct {
        logic [15:0] inst;
        logic [14:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [14:0] m_pc = '0;
    bit          m_live = 0;

    task automatic tick();
        bit pop, full;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_pc   = 15'd0;
            m_live = 1;
        end else begin
            pop = (mq.size() > 0) && fo_if.out_ready;
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc;
            end else begin
                full = (mq.size() == DEPTH);
                if (pop) void'(mq.pop_front());
                if (run && (!full || pop)) begin
                    mq.push_back('{mem[m_pc], m_pc});
                    m_pc = m_pc + 15'd1;
                end
            end
        end
        #1;
        if (m_live) begin
            chk("model rom_addr", 32'(rom_addr), 32'(m_pc));
            chk("model out_valid", 32'(fo_if.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("model out_pc", 32'(fo_if.out_pc), 32'(mq[0].pc));
                chk("model out_inst", 32'(fo_if.out_inst), 32'(mq[0].inst));
                chk("model out_is_a", 32'(fo_if.out_is_a), 32'(mq[0].inst[15] == 1'b0));
            end
        end
    endtask

    typedef struct {
        bit          rst_n, run, rdy, redir;
        logic [14:0] rpc;
        bit          ev;
        logic [14:0] epc;
        logic [15:0] einst;
        bit          eisa;
        logic [14:0] erom;
    } vec_t;

    function automatic vec_t v(bit r, bit rn, bit rd, bit rv, int rp,
                               bit ev, int epc, int ei, bit ea, int erom);
        vec_t t;
        t.rst_n = r;   t.run = rn;          t.rdy = rd;           t.redir = rv;
        t.rpc = 15'(rp); t.ev = ev;         t.epc = 15'(epc);     t.einst = 16'(ei);
        t.eisa = ea;   t.erom = 15'(erom);
        return t;
    endfunction

    vec_t tbl [21];

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'((i * 32'd2654435761) >> 7);
        mem[0]     = 16'h01F0;
        mem[1]     = 16'hEC10;
        mem[2]     = 16'h0010;
        mem[22]    = 16'h0016;
        mem[32767] = 16'hFFFF;

        //            rst run rdy redir rpc    ev  pc     inst      isa rom
        tbl[0]  = v(0, 1, 1, 0, 0,       0, 0,     0,        0,  0);
        tbl[1]  = v(1, 1, 1, 0, 0,       1, 0,     'h01F0,   1,  1);
        tbl[2]  = v(1, 1, 1, 0, 0,       1, 1,     'hEC10,   0,  2);
        tbl[3]  = v(0, 1, 1, 0, 0,       0, 0,     0,        0,  0);
        tbl[4]  = v(1, 1, 0, 0, 0,       1, 0,     'h01F0,   1,  1);
        tbl[5]  = v(1, 1, 0, 0, 0,       1, 0,     'h01F0,   1,  2);
        tbl[6]  = v(1, 1, 0, 0, 0,       1, 0,     'h01F0,   1,  2);
        tbl[7]  = v(1, 1, 1, 0, 0,       1, 1,     'hEC10,   0,  3);
        tbl[8]  = v(1, 1, 1, 0, 0,       1, 2,     'h0010,   1,  4);
        tbl[9]  = v(1, 1, 0, 0, 0,       1, 2,     'h0010,   1,  4);
        tbl[10] = v(1, 1, 0, 1, 22,      0, 0,     0,        0,  22);
        tbl[11] = v(1, 1, 0, 0, 0,       1, 22,    'h0016,   1,  23);
        tbl[12] = v(1, 1, 1, 1, 32767,   0, 0,     0,        0,  32767);
        tbl[13] = v(1, 1, 1, 0, 0,       1, 32767, 'hFFFF,   0,  0);
        tbl[14] = v(1, 1, 1, 0, 0,       1, 0,     'h01F0,   1,  1);
        tbl[15] = v(1, 1, 0, 0, 0,       1, 0,     'h01F0,   1,  2);
        tbl[16] = v(0, 1, 0, 1, 22,      0, 0,     0,        0,  0);
        tbl[17] = v(1, 1, 1, 0, 0,       1, 0,     'h01F0,   1,  1);
        tbl[18] = v(1, 0, 0, 0, 0,       1, 0,     'h01F0,   1,  1);
        tbl[19] = v(1, 0, 1, 0, 0,       0, 0,     0,        0,  1);
        tbl[20] = v(1, 0, 1, 0, 0,       0, 0,     0,        0,  1);

        fo_if.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 21; i++) begin
            rst_n           = tbl[i].rst_n;
            run             = tbl[i].run;
            fo_if.out_ready = tbl[i].rdy;
            redirect_valid  = tbl[i].redir;
            redirect_pc     = tbl[i].rpc;
            tick();
            chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(tbl[i].erom));
            chk($sformatf("vec%0d out_valid", i), 32'(fo_if.out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d out_pc", i), 32'(fo_if.out_pc), 32'(tbl[i].epc));
                chk($sformatf("vec%0d out_inst", i), 32'(fo_if.out_inst), 32'(tbl[i].einst));
                chk($sformatf("vec%0d out_is_a", i), 32'(fo_if.out_is_a), 32'(tbl[i].eisa));
            end
        end

        // Randomized traffic: stalls, run gaps, redirects (some near the wrap), rare resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            run             = ($urandom_range(0, 3) != 0);
            fo_if.out_ready = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 19) == 0);
            redirect_pc     = $urandom_range(0, 1) ? 15'(32765 + $urandom_range(0, 2))
                                                   : 15'($urandom_range(0, 32767));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
